// File: rtl/spi_pkg.sv
// Shared types, guard-time defaults and sizing helpers for the SPI burst controller.
package spi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StWaitTx,
      StLaunch,
      StXfer,
      StGap,
      StHold,
      StDone
   } spi_ctrl_state_e;

   typedef logic [7:0] byte_t;

   localparam int unsigned CsSetupDefault = 2;
   localparam int unsigned CsGapDefault   = 0;
   localparam int unsigned CsHoldDefault  = 10;

   // Guard counter reloads with N-1 so a phase lasts N cycles, never less than one.
   function automatic int unsigned guard_load(input int unsigned cycles);
      return (cycles > 0) ? cycles - 1 : 0;
   endfunction

   function automatic int unsigned guard_width(input int unsigned a, input int unsigned b,
                                               input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 0) ? $clog2(m + 1) : 1;
   endfunction

endpackage

// File: rtl/spi_guard_timer.sv
// Loadable down-counter timing the chip-select setup, inter-byte gap and hold phases.
module spi_guard_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer in front of the single-byte spi_master: owns the chip selects and
// their setup/gap/hold guard times, and moves one byte per spi_master transaction.
module spi_burst_ctrl
   import spi_pkg::*;
#(
   parameter  int unsigned NUM_SS   = 4,
   parameter  int unsigned LEN_W    = 8,
   parameter  int unsigned CS_SETUP = CsSetupDefault,
   parameter  int unsigned CS_GAP   = CsGapDefault,
   parameter  int unsigned CS_HOLD  = CsHoldDefault,
   localparam int unsigned SEL_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [SEL_W-1:0]  req_ss_sel,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              abort,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [7:0]        tx_data,
   output logic              rx_valid,
   output logic [7:0]        rx_data,
   output logic              busy,
   output logic              burst_done,
   output logic              burst_err,
   output logic              m_start,
   output logic [7:0]        m_tx_data,
   input  logic              m_tx_ready,
   input  logic              m_done,
   input  logic [7:0]        m_rx_data,
   output logic [NUM_SS-1:0] ss_n
);

   localparam int unsigned TW = guard_width(CS_SETUP, CS_GAP, CS_HOLD);
   localparam logic [TW-1:0] SetupLoad = TW'(guard_load(CS_SETUP));
   localparam logic [TW-1:0] GapLoad   = TW'(guard_load(CS_GAP));
   localparam logic [TW-1:0] HoldLoad  = TW'(guard_load(CS_HOLD));

   spi_ctrl_state_e   state_q, state_d;
   logic [NUM_SS-1:0] ss_n_q, ss_n_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              err_q, err_d;
   logic              abort_pend_q, abort_pend_d;
   byte_t             m_tx_data_q, m_tx_data_d;
   byte_t             rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;

   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic              tmr_expired;
   logic              sel_bad;
   logic [NUM_SS-1:0] sel_mask_n;

   spi_guard_timer #(
      .W(TW)
   ) u_guard_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (tmr_load),
      .load_val(tmr_val),
      .expired (tmr_expired)
   );

   assign sel_bad = (32'(req_ss_sel) >= NUM_SS);

   always_comb begin
      sel_mask_n = '1;
      for (int unsigned i = 0; i < NUM_SS; i++) begin
         sel_mask_n[i] = (32'(req_ss_sel) != i);
      end
   end

   always_comb begin
      state_d      = state_q;
      ss_n_d       = ss_n_q;
      rem_d        = rem_q;
      err_d        = err_q;
      abort_pend_d = abort_pend_q;
      m_tx_data_d  = m_tx_data_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      tx_ready     = 1'b0;
      m_start      = 1'b0;
      burst_done   = 1'b0;
      burst_err    = 1'b0;
      req_ready    = 1'b0;
      busy         = 1'b1;

      if (abort && state_q != StIdle && state_q != StDone) begin
         abort_pend_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               rem_d = req_len;
               err_d = sel_bad;
               // Empty or misaddressed bursts complete without touching the chip selects.
               if (req_len == '0 || sel_bad) begin
                  state_d = StDone;
               end else begin
                  ss_n_d   = sel_mask_n;
                  tmr_load = 1'b1;
                  tmr_val  = SetupLoad;
                  state_d  = StSetup;
               end
            end
         end
         StSetup: begin
            if (abort) begin
               tmr_load = 1'b1;
               tmr_val  = HoldLoad;
               state_d  = StHold;
            end else if (tmr_expired) begin
               state_d = StWaitTx;
            end
         end
         StWaitTx: begin
            tx_ready = m_tx_ready && !abort;
            if (abort) begin
               tmr_load = 1'b1;
               tmr_val  = HoldLoad;
               state_d  = StHold;
            end else if (tx_valid && m_tx_ready) begin
               m_tx_data_d = tx_data;
               state_d     = StLaunch;
            end
         end
         StLaunch: begin
            m_start = 1'b1;
            state_d = StXfer;
         end
         StXfer: begin
            if (m_done) begin
               rx_data_d  = m_rx_data;
               rx_valid_d = 1'b1;
               rem_d      = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1) || abort_pend_q || abort) begin
                  tmr_load = 1'b1;
                  tmr_val  = HoldLoad;
                  state_d  = StHold;
               end else if (CS_GAP > 0) begin
                  tmr_load = 1'b1;
                  tmr_val  = GapLoad;
                  state_d  = StGap;
               end else begin
                  state_d = StWaitTx;
               end
            end
         end
         StGap: begin
            if (abort) begin
               tmr_load = 1'b1;
               tmr_val  = HoldLoad;
               state_d  = StHold;
            end else if (tmr_expired) begin
               state_d = StWaitTx;
            end
         end
         StHold: begin
            if (tmr_expired) begin
               ss_n_d  = '1;
               state_d = StDone;
            end
         end
         StDone: begin
            burst_done   = 1'b1;
            burst_err    = err_q || abort_pend_q;
            err_d        = 1'b0;
            abort_pend_d = 1'b0;
            state_d      = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         ss_n_q       <= '1;
         rem_q        <= '0;
         err_q        <= 1'b0;
         abort_pend_q <= 1'b0;
         m_tx_data_q  <= 8'h00;
         rx_data_q    <= 8'h00;
         rx_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ss_n_q       <= ss_n_d;
         rem_q        <= rem_d;
         err_q        <= err_d;
         abort_pend_q <= abort_pend_d;
         m_tx_data_q  <= m_tx_data_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
      end
   end

   assign ss_n      = ss_n_q;
   assign m_tx_data = m_tx_data_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: a simple spi_master model answers each byte with byte^8'hF0
// and logs every DUT event by cycle; each test compares the logs with expected behaviour.
module tb_spi_burst_ctrl;

   localparam int unsigned NUM_SS   = 5;
   localparam int unsigned SEL_W    = 3;
   localparam int unsigned LEN_W    = 8;
   localparam int unsigned CS_SETUP = 2;
   localparam int unsigned CS_GAP   = 4;
   localparam int unsigned CS_HOLD  = 10;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic req_valid = 1'b0;
   logic req_ready;
   logic [SEL_W-1:0] req_ss_sel = '0;
   logic [LEN_W-1:0] req_len = '0;
   logic abort = 1'b0;
   logic tx_valid = 1'b0;
   logic tx_ready;
   logic [7:0] tx_data = 8'h00;
   logic rx_valid;
   logic [7:0] rx_data;
   logic busy, burst_done, burst_err, m_start;
   logic [7:0] m_tx_data;
   logic m_tx_ready = 1'b1;
   logic m_done = 1'b0;
   logic [7:0] m_rx_data = 8'h00;
   logic [NUM_SS-1:0] ss_n;

   spi_burst_ctrl #(
      .NUM_SS(NUM_SS), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP), .CS_HOLD(CS_HOLD)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_ss_sel(req_ss_sel), .req_len(req_len), .abort(abort), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
      .busy(busy), .burst_done(burst_done), .burst_err(burst_err), .m_start(m_start),
      .m_tx_data(m_tx_data), .m_tx_ready(m_tx_ready), .m_done(m_done),
      .m_rx_data(m_rx_data), .ss_n(ss_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   // Event logs filled by the master model; tests clear them before each burst.
   int                start_cyc[$];
   logic [7:0]        start_dat[$];
   int                done_cyc[$];
   int                rx_cyc[$];
   logic [7:0]        rx_dat[$];
   int                bd_cyc[$];
   logic              bd_err[$];
   int                ss_chg_cyc[$];
   logic [NUM_SS-1:0] ss_chg_val[$];
   logic [7:0]        tx_q[$];
   logic [NUM_SS-1:0] ss_prev = '1;
   int                multi_low = 0;
   bit                starve = 1'b0;
   int                force_lat = 0;
   int                mcnt = 0;
   logic [7:0]        pend = 8'h00;

   initial begin
      forever begin
         @(negedge clk);
         if (m_start) begin
            start_cyc.push_back(cyc);
            start_dat.push_back(m_tx_data);
            if (tx_q.size() > 0) void'(tx_q.pop_front());
         end
         if (rx_valid) begin
            rx_cyc.push_back(cyc);
            rx_dat.push_back(rx_data);
         end
         if (burst_done) begin
            bd_cyc.push_back(cyc);
            bd_err.push_back(burst_err);
         end
         if (ss_n !== ss_prev) begin
            ss_chg_cyc.push_back(cyc);
            ss_chg_val.push_back(ss_n);
            ss_prev = ss_n;
         end
         if ($countones(~ss_n) > 1) multi_low++;
         m_done = 1'b0;
         if (reset) begin
            mcnt = 0;
            m_tx_ready = 1'b1;
         end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
               m_done = 1'b1;
               m_rx_data = pend ^ 8'hF0;
               m_tx_ready = 1'b1;
               done_cyc.push_back(cyc);
            end
         end
         if (m_start && !reset) begin
            pend = m_tx_data;
            m_tx_ready = 1'b0;
            mcnt = (force_lat > 0) ? force_lat : int'($urandom_range(1, 6));
         end
         tx_valid = (tx_q.size() > 0) && !starve;
         tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
      end
   end

   task automatic clear_logs();
      start_cyc.delete(); start_dat.delete(); done_cyc.delete(); rx_cyc.delete();
      rx_dat.delete(); bd_cyc.delete(); bd_err.delete(); ss_chg_cyc.delete();
      ss_chg_val.delete();
   endtask

   task automatic issue_req(input int sel, input int len, output int rc);
      @(negedge clk);
      req_valid = 1'b1;
      req_ss_sel = sel[SEL_W-1:0];
      req_len = len[LEN_W-1:0];
      rc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      req_ss_sel = '0;
      req_len = '0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (bd_cyc.size() > 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      if (!ok) begin
         total++; bad++;
         $display("FAIL burst_timeout: got no burst_done, required one within 3000 cycles");
      end
   endtask

   task automatic wait_starts(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (start_cyc.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL start_timeout: got %0d m_start, required %0d", start_cyc.size(), n);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (ss_n !== '1) begin bad++; $display("FAIL rst_ss_n: got %b want 11111", ss_n); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
      total++; if ({m_start, rx_valid, burst_done, burst_err, tx_ready} !== 5'b0) begin
         bad++; $display("FAIL rst_pulses: got %b want 00000",
                         {m_start, rx_valid, burst_done, burst_err, tx_ready});
      end
      total++; if ({m_tx_data, rx_data} !== 16'h0000) begin
         bad++; $display("FAIL rst_data: got %h want 0000", {m_tx_data, rx_data});
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      int rc; bit ok;
      clear_logs();
      tx_q.push_back(8'h55);
      issue_req(1, 1, rc);
      wait_done(ok);
      total++; if (start_dat.size() != 1 || start_dat[0] !== 8'h55) begin
         bad++; $display("FAIL single_tx: got %0d starts first %h want 1 start 55",
                         start_dat.size(), start_dat[0]);
      end
      total++; if (ss_chg_val.size() != 2 || ss_chg_val[0] !== 5'b11101 || ss_chg_val[1] !== 5'b11111) begin
         bad++; $display("FAIL single_ss: got %0d changes %b then %b want 11101 then 11111",
                         ss_chg_val.size(), ss_chg_val[0], ss_chg_val[1]);
      end
      total++; if (start_cyc[0] - ss_chg_cyc[0] < int'(CS_SETUP)) begin
         bad++; $display("FAIL single_setup: got %0d cycles want >= %0d",
                         start_cyc[0] - ss_chg_cyc[0], CS_SETUP);
      end
      total++; if (rx_dat.size() != 1 || rx_dat[0] !== 8'hA5 || rx_cyc[0] != done_cyc[0] + 1) begin
         bad++; $display("FAIL single_rx: got %0d rx %h at +%0d want A5 at +1",
                         rx_dat.size(), rx_dat[0], rx_cyc[0] - done_cyc[0]);
      end
      total++; if (ss_chg_cyc[1] - done_cyc[0] != int'(CS_HOLD) + 1) begin
         bad++; $display("FAIL single_hold: got release %0d after m_done want %0d",
                         ss_chg_cyc[1] - done_cyc[0], CS_HOLD + 1);
      end
      total++; if (bd_cyc.size() != 1 || bd_cyc[0] != ss_chg_cyc[1] || bd_err[0] !== 1'b0) begin
         bad++; $display("FAIL single_done: got %0d pulses at %0d err %b want 1 at %0d err 0",
                         bd_cyc.size(), bd_cyc[0], bd_err[0], ss_chg_cyc[1]);
      end
   endtask

   task automatic test_gap();
      int rc; bit ok;
      logic [7:0] b[3];
      b[0] = 8'h12; b[1] = 8'h34; b[2] = 8'hAA;
      clear_logs();
      for (int i = 0; i < 3; i++) tx_q.push_back(b[i]);
      issue_req(0, 3, rc);
      wait_done(ok);
      total++; if (start_cyc.size() != 3 || rx_dat.size() != 3) begin
         bad++; $display("FAIL gap_count: got %0d starts %0d rx want 3 and 3",
                         start_cyc.size(), rx_dat.size());
      end
      for (int i = 0; i < 3; i++) begin
         total++; if (start_dat[i] !== b[i] || rx_dat[i] !== (b[i] ^ 8'hF0)) begin
            bad++; $display("FAIL gap_byte%0d: got tx %h rx %h want tx %h rx %h",
                            i, start_dat[i], rx_dat[i], b[i], b[i] ^ 8'hF0);
         end
      end
      for (int i = 1; i < 3; i++) begin
         total++; if (start_cyc[i] - done_cyc[i-1] - 1 < int'(CS_GAP)) begin
            bad++; $display("FAIL gap_idle%0d: got %0d idle cycles want >= %0d",
                            i, start_cyc[i] - done_cyc[i-1] - 1, CS_GAP);
         end
      end
      total++; if (ss_chg_val.size() != 2 || ss_chg_val[0] !== 5'b11110) begin
         bad++; $display("FAIL gap_ss: got %0d changes first %b want 2 first 11110",
                         ss_chg_val.size(), ss_chg_val[0]);
      end
   endtask

   task automatic test_starve();
      int rc; bit ok;
      logic [7:0] b0, b1;
      b0 = 8'($urandom); b1 = 8'($urandom);
      clear_logs();
      tx_q.push_back(b0); tx_q.push_back(b1);
      issue_req(2, 2, rc);
      wait_starts(1, ok);
      starve = 1'b1;
      repeat (50) @(negedge clk);
      total++; if (start_cyc.size() != 1) begin
         bad++; $display("FAIL starve_start: got %0d m_start want 1", start_cyc.size());
      end
      total++; if (ss_n !== 5'b11011 || ss_chg_cyc.size() != 1 || busy !== 1'b1) begin
         bad++; $display("FAIL starve_ss: got ss_n %b changes %0d busy %b want 11011 1 1",
                         ss_n, ss_chg_cyc.size(), busy);
      end
      starve = 1'b0;
      wait_done(ok);
      total++; if (rx_dat.size() != 2 || rx_dat[0] !== (b0 ^ 8'hF0) || rx_dat[1] !== (b1 ^ 8'hF0)) begin
         bad++; $display("FAIL starve_rx: got %0d rx %h %h want %h %h",
                         rx_dat.size(), rx_dat[0], rx_dat[1], b0 ^ 8'hF0, b1 ^ 8'hF0);
      end
      total++; if (bd_err[0] !== 1'b0 || ss_chg_cyc.size() != 2) begin
         bad++; $display("FAIL starve_done: got err %b changes %0d want 0 2",
                         bd_err[0], ss_chg_cyc.size());
      end
   endtask

   task automatic test_abort();
      int rc; bit ok;
      logic [7:0] b[4];
      clear_logs();
      for (int i = 0; i < 4; i++) begin
         b[i] = 8'($urandom);
         tx_q.push_back(b[i]);
      end
      force_lat = 8;
      issue_req(3, 4, rc);
      wait_starts(1, ok);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done(ok);
      force_lat = 0;
      total++; if (start_cyc.size() != 1 || tx_q.size() != 3) begin
         bad++; $display("FAIL abort_starts: got %0d starts %0d unsent want 1 and 3",
                         start_cyc.size(), tx_q.size());
      end
      total++; if (rx_dat.size() != 1 || rx_dat[0] !== (b[0] ^ 8'hF0)) begin
         bad++; $display("FAIL abort_rx: got %0d rx %h want 1 rx %h",
                         rx_dat.size(), rx_dat[0], b[0] ^ 8'hF0);
      end
      total++; if (ss_chg_cyc[1] - done_cyc[0] != int'(CS_HOLD) + 1) begin
         bad++; $display("FAIL abort_hold: got release %0d after m_done want %0d",
                         ss_chg_cyc[1] - done_cyc[0], CS_HOLD + 1);
      end
      total++; if (bd_err[0] !== 1'b1) begin
         bad++; $display("FAIL abort_err: got %b want 1", bd_err[0]);
      end
      tx_q.delete();
   endtask

   task automatic test_degenerate();
      int rc; bit ok;
      clear_logs();
      issue_req(int'($urandom_range(0, NUM_SS - 1)), 0, rc);
      wait_done(ok);
      total++; if (bd_cyc[0] - rc > 2 || bd_err[0] !== 1'b0 || ss_chg_cyc.size() != 0) begin
         bad++; $display("FAIL len0: got done +%0d err %b ss changes %0d want <=2 0 0",
                         bd_cyc[0] - rc, bd_err[0], ss_chg_cyc.size());
      end
      clear_logs();
      issue_req(int'(NUM_SS), 3, rc);
      wait_done(ok);
      total++; if (bd_cyc[0] - rc > 2 || bd_err[0] !== 1'b1 || ss_chg_cyc.size() != 0
                   || start_cyc.size() != 0) begin
         bad++; $display("FAIL badsel: got done +%0d err %b ss changes %0d starts %0d want <=2 1 0 0",
                         bd_cyc[0] - rc, bd_err[0], ss_chg_cyc.size(), start_cyc.size());
      end
   endtask

   task automatic test_random();
      int rc, sel, len; bit ok;
      logic [7:0] b[$];
      logic [NUM_SS-1:0] exp_ss;
      for (int k = 0; k < 6; k++) begin
         sel = int'($urandom_range(0, NUM_SS - 1));
         len = int'($urandom_range(1, 5));
         b.delete();
         clear_logs();
         for (int i = 0; i < len; i++) begin
            b.push_back(8'($urandom));
            tx_q.push_back(b[i]);
         end
         exp_ss = '1;
         exp_ss[sel] = 1'b0;
         issue_req(sel, len, rc);
         wait_done(ok);
         total++; if (rx_dat.size() != len || start_cyc.size() != len) begin
            bad++; $display("FAIL rand%0d_count: got %0d rx %0d starts want %0d",
                            k, rx_dat.size(), start_cyc.size(), len);
         end
         for (int i = 0; i < len; i++) begin
            total++; if (rx_dat[i] !== (b[i] ^ 8'hF0)) begin
               bad++; $display("FAIL rand%0d_rx%0d: got %h want %h", k, i, rx_dat[i], b[i] ^ 8'hF0);
            end
         end
         total++; if (ss_chg_val.size() != 2 || ss_chg_val[0] !== exp_ss || bd_err[0] !== 1'b0) begin
            bad++; $display("FAIL rand%0d_ss: got %0d changes %b err %b want 2 %b 0",
                            k, ss_chg_val.size(), ss_chg_val[0], bd_err[0], exp_ss);
         end
      end
   endtask

   task automatic test_reset_hold();
      int rc; bit ok;
      clear_logs();
      tx_q.push_back(8'($urandom));
      issue_req(4, 1, rc);
      for (int i = 0; i < 200 && done_cyc.size() == 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b1 || ss_n !== 5'b01111) begin
         bad++; $display("FAIL hold_pre: got busy %b ss_n %b want 1 01111", busy, ss_n);
      end
      #2 reset = 1'b1;
      #1;
      total++; if (ss_n !== '1 || busy !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL hold_reset: got ss_n %b busy %b req_ready %b want 11111 0 1",
                         ss_n, busy, req_ready);
      end
      total++; if ({m_start, rx_valid, burst_done, tx_ready, m_tx_data, rx_data} !== 20'h0) begin
         bad++; $display("FAIL hold_reset_out: got %h want 00000",
                         {m_start, rx_valid, burst_done, tx_ready, m_tx_data, rx_data});
      end
      @(negedge clk);
      reset = 1'b0;
      total++; if (bd_cyc.size() != 0) begin
         bad++; $display("FAIL hold_no_done: got %0d burst_done want 0", bd_cyc.size());
      end
      clear_logs();
      tx_q.push_back(8'h3C);
      issue_req(0, 1, rc);
      wait_done(ok);
      total++; if (rx_dat.size() != 1 || rx_dat[0] !== 8'hCC || bd_err[0] !== 1'b0) begin
         bad++; $display("FAIL after_reset: got %0d rx %h err %b want 1 CC 0",
                         rx_dat.size(), rx_dat[0], bd_err[0]);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_gap();
      test_starve();
      test_abort();
      test_degenerate();
      test_random();
      test_reset_hold();
      total++; if (multi_low != 0) begin
         bad++; $display("FAIL one_hot_ss: got %0d cycles with several ss_n low want 0", multi_low);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
